// File: rtl/sdram_pkg.sv
// Shared types and default widths for the SDRAM write-path blocks.
package sdram_pkg;
  localparam int SDRAM_DATA_SZ    = 32;
  localparam int SDRAM_ADDR_SZ    = 10;
  localparam int SDRAM_LEN_SZ     = 4;
  localparam int SDRAM_GAP_CNT_SZ = 4;

  localparam logic SDRAM_CMD_BEAT = 1'b1;
  localparam logic SDRAM_CMD_NOP  = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } sdram_seq_state_e;
endpackage

// File: rtl/sdram_wdata_fifo.sv
// Synchronous write-data FIFO; dout_o shows the head entry, a push becomes visible the next cycle.
// Pushes while full and pops while empty are ignored; push and pop together leave the count unchanged.
module sdram_wdata_fifo #(
  parameter int DATA_SZ_P = 32,
  parameter int DEPTH_P   = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DATA_SZ_P-1:0] din_i,
  output logic [DATA_SZ_P-1:0] dout_o,
  output logic                 full_o,
  output logic                 empty_o
);
  localparam int PTR_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH_P);

  logic [DATA_SZ_P-1:0] mem_q [DEPTH_P];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/sdram_wr_sequencer.sv
// Burst write sequencer: buffers write data and drives one registered SDRAM beat per cycle from a base address.
// First beat two cycles after request acceptance; wdata_ready_o drops when the FIFO is full, starvation inserts bubbles.
module sdram_wr_sequencer
  import sdram_pkg::*;
#(
  parameter int DATA_SZ_P    = SDRAM_DATA_SZ,
  parameter int ADDR_SZ_P    = SDRAM_ADDR_SZ,
  parameter int LEN_SZ_P     = SDRAM_LEN_SZ,
  parameter int FIFO_DEPTH_P = 4,
  parameter int GAP_P        = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_SZ_P-1:0] req_addr_i,
  input  logic [LEN_SZ_P-1:0]  req_len_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  input  logic [DATA_SZ_P-1:0] wdata_i,
  output logic                 cmd_o,
  output logic [ADDR_SZ_P-1:0] addr_o,
  output logic [DATA_SZ_P-1:0] data_o,
  output logic                 busy_o
);
  typedef struct packed {
    logic [ADDR_SZ_P-1:0] base;
    logic [LEN_SZ_P-1:0]  last;
    logic [LEN_SZ_P-1:0]  beat;
  } burst_ctx_t;

  sdram_seq_state_e            state_q, state_d;
  burst_ctx_t                  ctx_q, ctx_d;
  logic [SDRAM_GAP_CNT_SZ-1:0] gap_q, gap_d;
  logic                        cmd_q, cmd_d;
  logic [ADDR_SZ_P-1:0]        addr_q, addr_d;
  logic [DATA_SZ_P-1:0]        data_q, data_d;

  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_SZ_P-1:0]        fifo_dout;

  assign wdata_ready_o = !fifo_full;
  assign fifo_push     = wdata_valid_i && !fifo_full;
  assign fifo_pop      = (state_q == BURST) && !fifo_empty;
  assign req_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);

  sdram_wdata_fifo #(
    .DATA_SZ_P (DATA_SZ_P),
    .DEPTH_P   (FIFO_DEPTH_P)
  ) u_wdata_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (wdata_i),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    gap_d   = gap_q;
    cmd_d   = SDRAM_CMD_NOP;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          ctx_d.base = req_addr_i;
          ctx_d.last = req_len_i;
          ctx_d.beat = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // An empty FIFO simply leaves a bubble; the beat index does not advance.
        if (fifo_pop) begin
          cmd_d      = SDRAM_CMD_BEAT;
          addr_d     = ctx_q.base + ADDR_SZ_P'(ctx_q.beat);
          data_d     = fifo_dout;
          ctx_d.beat = ctx_q.beat + 1'b1;
          if (ctx_q.beat == ctx_q.last) begin
            if (GAP_P != 0) begin
              state_d = GAP;
              gap_d   = SDRAM_GAP_CNT_SZ'(GAP_P);
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= SDRAM_GAP_CNT_SZ'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ctx_q   <= '0;
      gap_q   <= '0;
      cmd_q   <= SDRAM_CMD_NOP;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      gap_q   <= gap_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign cmd_o  = cmd_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
endmodule

// File: tb/tb_sdram_wr_sequencer.sv
// Scoreboard bench for sdram_wr_sequencer: beats are predicted from accepted requests and pushed words.
module tb_sdram_wr_sequencer;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int LW    = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [LW-1:0] req_len_i;
  logic          wdata_valid_i;
  logic          wdata_ready_o;
  logic [DW-1:0] wdata_i;
  logic          cmd_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic          busy_o;

  sdram_wr_sequencer #(
    .DATA_SZ_P    (DW),
    .ADDR_SZ_P    (AW),
    .LEN_SZ_P     (LW),
    .FIFO_DEPTH_P (DEPTH),
    .GAP_P        (GAP)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_len_i     (req_len_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_ready_o (wdata_ready_o),
    .wdata_i       (wdata_i),
    .cmd_o         (cmd_o),
    .addr_o        (addr_o),
    .data_o        (data_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] aq[$];
  logic [DW-1:0] dq[$];
  int            cmd_cyc_q[$];
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor and recorder: compare beats against the model, then log handshakes for the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      aq.delete();
      dq.delete();
      exp_addr = '0;
      exp_data = '0;
      check("rst_cmd", 32'(cmd_o), 32'd0);
      check("rst_addr", 32'(addr_o), 32'd0);
      check("rst_data", data_o, 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_req_ready", 32'(req_ready_o), 32'd1);
      check("rst_wdata_ready", 32'(wdata_ready_o), 32'd1);
    end else begin
      if (cmd_o) begin
        cmd_cyc_q.push_back(cyc);
        if (aq.size() == 0 || dq.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          exp_addr = aq.pop_front();
          exp_data = dq.pop_front();
          check("beat_addr", 32'(addr_o), 32'(exp_addr));
          check("beat_data", data_o, exp_data);
        end
      end else begin
        check("hold_addr", 32'(addr_o), 32'(exp_addr));
        check("hold_data", data_o, exp_data);
      end
      if (wdata_valid_i && wdata_ready_o) dq.push_back(wdata_i);
      if (req_valid_i && req_ready_o)
        for (int i = 0; i <= int'(req_len_i); i++) aq.push_back(AW'(int'(req_addr_i) + i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w, output int hcyc);
    bit done = 0;
    int n = 0;
    hcyc = -1;
    wdata_i = w;
    wdata_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (wdata_ready_o) begin
        done = 1;
        hcyc = cyc;
      end
      tick();
      n++;
      if (!done && n > 300) begin
        fail_now("push_timeout");
        done = 1;
      end
    end
    wdata_valid_i = 1'b0;
  endtask

  task automatic send_req(input logic [AW-1:0] a, input logic [LW-1:0] l, output int acc);
    bit done = 0;
    int n = 0;
    acc = -1;
    req_addr_i = a;
    req_len_i = l;
    req_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (req_ready_o) begin
        done = 1;
        acc = cyc;
      end
      tick();
      n++;
      if (!done && n > 300) begin
        fail_now("req_timeout");
        done = 1;
      end
    end
    req_valid_i = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (cmd_cyc_q.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (cmd_cyc_q.size() < n) fail_now("beat_timeout");
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(req_ready_o && aq.size() == 0) && t < 400);
    if (t >= 400) fail_now("idle_timeout");
    tick();
  endtask

  task automatic data_stream(input int n);
    int h;
    for (int i = 0; i < n; i++) begin
      push_word($urandom, h);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  int h, acc, acc1, acc2, p0, m;
  logic [DW-1:0] w;

  initial begin
    reset = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i = '0;
    req_len_i = '0;
    wdata_valid_i = 1'b0;
    wdata_i = '0;
    repeat (3) @(negedge clk);
    tick();
    reset = 1'b0;
    tick();

    // Single beat, then the idle gap after it.
    push_word(32'hA5A5_0001, h);
    cmd_cyc_q.delete();
    send_req(10'h010, 4'd0, acc);
    wait_beats(1);
    m = cmd_cyc_q[0];
    check("single_first_cmd_cycle", 32'(m), 32'(acc + 2));
    for (int k = 1; k <= GAP; k++) begin
      while (cyc < m + k) @(negedge clk);
      check("single_busy_gap", 32'(busy_o), (k < GAP) ? 32'd1 : 32'd0);
      check("single_req_ready_gap", 32'(req_ready_o), (k < GAP) ? 32'd0 : 32'd1);
    end
    wait_idle();
    check("single_beat_count", 32'(cmd_cyc_q.size()), 32'd1);

    // Address wrap with a prefilled FIFO.
    for (int i = 0; i < 4; i++) push_word($urandom, h);
    cmd_cyc_q.delete();
    send_req(10'h3FE, 4'd3, acc);
    wait_beats(4);
    check("wrap_first_cmd_cycle", 32'(cmd_cyc_q[0]), 32'(acc + 2));
    check("wrap_consecutive", 32'(cmd_cyc_q[3] - cmd_cyc_q[0]), 32'd3);
    wait_idle();

    // Starvation: one word every three cycles.
    cmd_cyc_q.delete();
    send_req(10'h120, 4'd3, acc);
    for (int i = 0; i < 4; i++) begin
      push_word($urandom, h);
      if (i == 0) p0 = h;
      repeat (2) tick();
    end
    wait_beats(4);
    check("starve_first_cmd", 32'(cmd_cyc_q[0]), 32'(p0 + 2));
    for (int i = 1; i < 4; i++)
      check("starve_spacing", 32'(cmd_cyc_q[i] - cmd_cyc_q[i-1]), 32'd3);
    wait_idle();

    // Back-to-back requests with continuous data.
    for (int i = 0; i < 4; i++) push_word($urandom, h);
    cmd_cyc_q.delete();
    fork
      begin
        send_req(10'h200, 4'd3, acc1);
        send_req(10'h080, 4'd2, acc2);
      end
      begin
        for (int i = 0; i < 3; i++) push_word($urandom, h);
      end
    join
    wait_beats(7);
    check("b2b_burst1_consecutive", 32'(cmd_cyc_q[3] - cmd_cyc_q[0]), 32'd3);
    check("b2b_req_ready_return", 32'(acc2 - cmd_cyc_q[3]), 32'(GAP));
    check("b2b_burst_spacing", 32'(cmd_cyc_q[4] - cmd_cyc_q[3]), 32'(GAP + 2));
    wait_idle();

    // Backpressure: fifth word waits for the first pop.
    for (int i = 0; i < 4; i++) push_word($urandom, h);
    @(negedge clk);
    check("bp_wdata_ready_full", 32'(wdata_ready_o), 32'd0);
    tick();
    fork
      push_word($urandom, h);
      begin
        repeat (3) tick();
        send_req(10'h055, 4'd4, acc);
      end
    join
    check("bp_fifth_accept_cycle", 32'(h), 32'(acc + 2));
    wait_idle();

    // Reset in the middle of a len=7 burst.
    for (int i = 0; i < 4; i++) push_word($urandom, h);
    cmd_cyc_q.delete();
    send_req(10'h300, 4'd7, acc);
    wait_beats(2);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_cmd", 32'(cmd_o), 32'd0);
    check("midrst_addr", 32'(addr_o), 32'd0);
    check("midrst_data", data_o, 32'd0);
    repeat (2) @(negedge clk);
    tick();
    reset = 1'b0;
    cmd_cyc_q.delete();
    send_req(10'h155, 4'd0, acc);
    repeat (6) tick();
    check("midrst_fifo_empty", 32'(cmd_cyc_q.size()), 32'd0);
    w = $urandom;
    push_word(w, h);
    wait_beats(1);
    check("midrst_fresh_cmd_cycle", 32'(cmd_cyc_q[0]), 32'(h + 2));
    wait_idle();

    // Randomized bursts with irregular data arrival.
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(0, 15);
      fork
        send_req(AW'($urandom_range(0, 1023)), LW'(len), acc);
        data_stream(len + 1);
      join
      wait_idle();
    end

    repeat (4) tick();
    check("scoreboard_addr_drained", 32'(aq.size()), 32'd0);
    check("scoreboard_data_drained", 32'(dq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end
endmodule
